// File: rtl/qpd_pkg.sv
// Shared types and constants for the quarter-period delay sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package qpd_pkg;

    localparam int PCT_W    = 7;
    localparam int PCT_FULL = 100;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        ARM,
        DELAY,
        FIRE,
        WAIT_DONE
    } state_t;

    // A percentage is usable only in 1..PCT_FULL; 0 and anything above are rejected.
    function automatic logic pct_legal(input logic [PCT_W-1:0] pct);
        return (pct != '0) && (pct <= PCT_W'(PCT_FULL));
    endfunction

endpackage

// File: rtl/qpd_delay_calc.sv
// Scales a quarter-period count by a percentage: delay = floor(qp * pct / 100).
// Latency: combinational; the caller registers the result.
// Backpressure: none.
module qpd_delay_calc
    import qpd_pkg::*;
#(
    parameter int QP_W = 8
) (
    input  logic [QP_W-1:0]  qp,
    input  logic [PCT_W-1:0] pct,
    output logic [QP_W-1:0]  delay
);

    // Full-width product so qp*pct never wraps; the quotient fits back in QP_W
    // because pct never exceeds 100.
    localparam int PROD_W = QP_W + PCT_W;
    localparam logic [PROD_W-1:0] DIVISOR = PROD_W'(PCT_FULL);

    logic [PROD_W-1:0] prod;

    assign prod  = PROD_W'(qp) * PROD_W'(pct);
    assign delay = QP_W'(prod / DIVISOR);

endmodule

// File: rtl/qpd_sequencer.sv
// Quarter-period delay sequencer: accepts a percentage command, waits for a sync
// rising edge, fires trig_out after the scaled delay, then waits for meas_done.
// Latency: trig_out is high in the cycle after edge k+D+1 for a sync edge seen at edge k.
// Backpressure: cmd_ready is high only while idle; meas_done is bounded by TIMEOUT_CYCLES.
// Optional: define QPD_SEQ_REF_EN to follow each non-100 % run with a 100 % reference run.
module qpd_sequencer
    import qpd_pkg::*;
#(
    parameter int QP_W           = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic             sclock,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [PCT_W-1:0] cmd_pct,
    input  logic [QP_W-1:0]  qp_count,
    input  logic             sync,
    input  logic             meas_done,
    output logic             trig_out,
    output logic             busy,
    output logic             phase_ref,
    output logic             err
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [PCT_W-1:0] pct_q;
    logic [QP_W-1:0]  qp_q;
    logic [QP_W-1:0]  d_q;
    logic [QP_W-1:0]  d_calc;
    logic [QP_W-1:0]  dly_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             sync_q;
    logic             sync_rise;

    qpd_delay_calc #(
        .QP_W (QP_W)
    ) u_delay_calc (
        .qp    (qp_q),
        .pct   (pct_q),
        .delay (d_calc)
    );

    assign sync_rise = sync && !sync_q;

    // Previous-cycle copy of sync for rising-edge detection.
    always_ff @(posedge sclock or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b0;
        end else begin
            sync_q <= sync;
        end
    end

`ifdef QPD_SEQ_REF_EN
    logic ref_run;

    // Marks the automatic 100 % run; armed when a test run ends normally, cleared on
    // the end of the reference run or on any timeout.
    always_ff @(posedge sclock or negedge rst_n) begin
        if (!rst_n) begin
            ref_run <= 1'b0;
        end else if (state == WAIT_DONE) begin
            if (meas_done) begin
                ref_run <= !ref_run && (pct_q != PCT_W'(PCT_FULL));
            end else if (to_cnt == TO_LAST) begin
                ref_run <= 1'b0;
            end
        end
    end

    assign phase_ref = ref_run;
`else
    assign phase_ref = 1'b0;
`endif

    // Main sequencer; all outputs are registered alongside the state.
    always_ff @(posedge sclock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            trig_out  <= 1'b0;
            err       <= 1'b0;
            pct_q     <= '0;
            qp_q      <= '0;
            d_q       <= '0;
            dly_cnt   <= '0;
            to_cnt    <= '0;
        end else begin
            trig_out <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        if (pct_legal(cmd_pct)) begin
                            pct_q     <= cmd_pct;
                            qp_q      <= qp_count;
                            state     <= CALC;
                            cmd_ready <= 1'b0;
                            busy      <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    d_q   <= d_calc;
                    state <= ARM;
                end
                ARM: begin
                    if (sync_rise) begin
                        dly_cnt <= '0;
                        state   <= DELAY;
                    end
                end
                DELAY: begin
                    // Count starts on the edge after detection, so D=0 fires one edge later.
                    if (dly_cnt == d_q) begin
                        trig_out <= 1'b1;
                        state    <= FIRE;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                FIRE: begin
                    to_cnt <= '0;
                    state  <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // meas_done wins over a coincident timeout.
                    if (meas_done) begin
`ifdef QPD_SEQ_REF_EN
                        if (!ref_run && (pct_q != PCT_W'(PCT_FULL))) begin
                            pct_q <= PCT_W'(PCT_FULL);
                            state <= CALC;
                        end else begin
                            state     <= IDLE;
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                        end
`else
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
`endif
                    end else if (to_cnt == TO_LAST) begin
                        err       <= 1'b1;
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qpd_sequencer.sv
// Randomized scoreboard bench for qpd_sequencer.
// Latency: n/a.
// Backpressure: n/a.
module tb_qpd_sequencer;

    localparam int QP_W = 8;
    localparam int TO   = 16;
`ifdef QPD_SEQ_REF_EN
    localparam bit REF_EN = 1'b1;
`else
    localparam bit REF_EN = 1'b0;
`endif

    logic            sclock    = 1'b0;
    logic            rst_n     = 1'b0;
    logic            cmd_valid = 1'b0;
    logic [6:0]      cmd_pct   = '0;
    logic [QP_W-1:0] qp_count  = '0;
    logic            sync      = 1'b0;
    logic            meas_done = 1'b0;
    logic            cmd_ready;
    logic            trig_out;
    logic            busy;
    logic            phase_ref;
    logic            err;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int   t;
        logic r;
    } trig_exp_t;

    trig_exp_t trig_q[$];
    int        err_q[$];

    qpd_sequencer #(
        .QP_W           (QP_W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .sclock    (sclock),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_pct   (cmd_pct),
        .qp_count  (qp_count),
        .sync      (sync),
        .meas_done (meas_done),
        .trig_out  (trig_out),
        .busy      (busy),
        .phase_ref (phase_ref),
        .err       (err)
    );

    always #5 sclock = ~sclock;

    always @(posedge sclock) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp_v);
        end
    endtask

    // Monitor: every trig_out / err pulse must match the head of its queue.
    always @(negedge sclock) begin
        trig_exp_t e;
        if (rst_n) begin
            if (trig_out) begin
                chk("trig_expected", int'(trig_q.size() > 0), 1);
                if (trig_q.size() > 0) begin
                    e = trig_q.pop_front();
                    chk("trig_cycle", cyc, e.t);
                    chk("trig_phase_ref", int'(phase_ref), int'(e.r));
                end
            end else if (trig_q.size() > 0 && trig_q[0].t < cyc) begin
                chk("trig_deadline", cyc, trig_q[0].t);
                void'(trig_q.pop_front());
            end
            if (err) begin
                chk("err_expected", int'(err_q.size() > 0), 1);
                if (err_q.size() > 0) begin
                    chk("err_cycle", cyc, err_q.pop_front());
                end
            end else if (err_q.size() > 0 && err_q[0] < cyc) begin
                chk("err_deadline", cyc, err_q[0]);
                void'(err_q.pop_front());
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Raise sync, predict the trigger, and stir sync/cmd/meas_done while counting.
    task automatic fire_phase(input int d, input bit r, output int t_trig);
        trig_exp_t e;
        sync   = 1'b1;
        t_trig = cyc + 1 + d + 1;
        e.t = t_trig;
        e.r = r;
        trig_q.push_back(e);
        for (int i = 0; i < 8; i++) begin
            @(negedge sclock);
            if (cyc + 1 >= t_trig) break;
            sync      = 1'($urandom);
            meas_done = ($urandom_range(0, 3) == 0);
            cmd_valid = 1'($urandom);
            cmd_pct   = 7'($urandom_range(1, 100));
            chk("ready_while_busy", int'(cmd_ready), 0);
        end
        sync      = 1'b0;
        meas_done = 1'b0;
        cmd_valid = 1'b0;
    endtask

    // mode 0: meas_done somewhere in the window, 1: timeout, 2: meas_done on the last cycle.
    task automatic finish_phase(input int t_trig, input int mode, input bit r, output bit done);
        int m;
        if (mode == 1) begin
            err_q.push_back(t_trig + 1 + TO);
            while (cyc < t_trig + 1 + TO) @(negedge sclock);
            chk("busy_after_timeout", int'(busy), 0);
            chk("phase_ref_after_timeout", int'(phase_ref), 0);
            repeat (4) @(negedge sclock);
            chk("busy_stays_idle_after_timeout", int'(busy), 0);
            done = 1'b0;
        end else begin
            m = (mode == 2) ? t_trig + 1 + TO : t_trig + 2 + int'($urandom_range(0, TO - 1));
            while (cyc < m - 1) @(negedge sclock);
            chk("phase_ref_in_wait", int'(phase_ref), int'(r));
            meas_done = 1'b1;
            @(negedge sclock);
            meas_done = 1'b0;
            done = 1'b1;
        end
    endtask

    task automatic run_meas(input int pct, input int qp, input int mode);
        int t0;
        int t_trig;
        bit legal;
        bit done;
        bit exp_ref;
        legal = (pct >= 1) && (pct <= 100);
        t0 = cyc;
        while (!cmd_ready && (cyc - t0) < 2000) @(negedge sclock);
        chk("ready_before_offer", int'(cmd_ready), 1);
        if (!cmd_ready) return;
        cmd_valid = 1'b1;
        cmd_pct   = 7'(pct);
        qp_count  = QP_W'(qp);
        if (!legal) err_q.push_back(cyc + 1);
        @(negedge sclock);
        cmd_valid = 1'b0;
        cmd_pct   = 7'($urandom);
        qp_count  = QP_W'($urandom);
        if (!legal) begin
            chk("busy_after_reject", int'(busy), 0);
            chk("ready_after_reject", int'(cmd_ready), 1);
            @(negedge sclock);
            return;
        end
        repeat (2 + $urandom_range(0, 3)) @(negedge sclock);
        chk("busy_in_arm", int'(busy), 1);
        chk("ready_in_arm", int'(cmd_ready), 0);
        fire_phase((qp * pct) / 100, 1'b0, t_trig);
        finish_phase(t_trig, mode, 1'b0, done);
        exp_ref = REF_EN && done && (pct != 100);
        if (done) begin
            chk("busy_after_done", int'(busy), int'(exp_ref));
            chk("phase_ref_after_done", int'(phase_ref), int'(exp_ref));
        end
        if (exp_ref) begin
            repeat (3 + $urandom_range(0, 3)) @(negedge sclock);
            fire_phase(qp, 1'b1, t_trig);
            finish_phase(t_trig, ($urandom_range(0, 5) == 0) ? 1 : 0, 1'b1, done);
            chk("busy_after_ref", int'(busy), 0);
            chk("phase_ref_after_ref", int'(phase_ref), 0);
        end
        repeat (2) @(negedge sclock);
    endtask

    initial begin
        int pct;
        int mode;
        @(negedge sclock);
        chk("reset_cmd_ready", int'(cmd_ready), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_trig", int'(trig_out), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_phase_ref", int'(phase_ref), 0);
        repeat (2) @(negedge sclock);
        rst_n = 1'b1;
        @(negedge sclock);
        chk("ready_after_release", int'(cmd_ready), 1);
        chk("busy_after_release", int'(busy), 0);

        run_meas(25, 24, 0);
        run_meas(75, 25, 0);
        run_meas(0, 50, 0);
        run_meas(101, 50, 0);
        run_meas(50, 40, 1);
        run_meas(50, 40, 2);
        run_meas(100, 0, 0);
        run_meas(1, 255, 0);

        // Reset in the middle of a long delay: no trigger may ever appear.
        while (!cmd_ready) @(negedge sclock);
        cmd_valid = 1'b1;
        cmd_pct   = 7'd100;
        qp_count  = 8'd200;
        @(negedge sclock);
        cmd_valid = 1'b0;
        repeat (3) @(negedge sclock);
        sync = 1'b1;
        repeat (20) @(negedge sclock);
        chk("busy_mid_delay", int'(busy), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("busy_at_reset", int'(busy), 0);
        chk("trig_at_reset", int'(trig_out), 0);
        chk("ready_at_reset", int'(cmd_ready), 0);
        sync = 1'b0;
        repeat (3) @(negedge sclock);
        chk("ready_held_in_reset", int'(cmd_ready), 0);
        rst_n = 1'b1;
        @(negedge sclock);
        chk("ready_after_mid_reset", int'(cmd_ready), 1);
        chk("busy_after_mid_reset", int'(busy), 0);
        repeat (230) @(negedge sclock);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0:       pct = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(101, 127));
                1:       pct = 100;
                default: pct = int'($urandom_range(1, 99));
            endcase
            case ($urandom_range(0, 5))
                0:       mode = 1;
                1:       mode = 2;
                default: mode = 0;
            endcase
            run_meas(pct, int'($urandom_range(0, 255)), mode);
        end

        repeat (30) @(negedge sclock);
        chk("trig_queue_drained", trig_q.size(), 0);
        chk("err_queue_drained", err_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
